// File: rtl/sensor_measure_scheduler.sv
// sensor_measure_scheduler
// Keeps at most one HC-SR04 or DHT11 transaction in flight at a time. Each
// sensor has one pending request slot, and the two sensors take turns when
// both are waiting. The block holds back DHT11 starts until a minimum gap has
// passed since the last DHT11 grant. A 1 kHz tick drives a watchdog that
// aborts any transaction whose done pulse does not arrive in time.
module sensor_measure_scheduler #(
    parameter int HCSR_TIMEOUT_MS = 60,
    parameter int DHT_TIMEOUT_MS  = 30,
    parameter int DHT_MIN_GAP_MS  = 1000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick1kHz,
    input  logic       iHcsrReq,
    input  logic       iDht11Req,
    input  logic       iHcsrDone,
    input  logic       iDht11Done,
    output logic       oHcsrStart,
    output logic       oDht11Start,
    output logic       oHcsrTimeout,
    output logic       oDht11Timeout,
    output logic       oOverrun,
    output logic       oBusy,
    output logic [1:0] oActive
);

    localparam logic [10:0] GAP_FULL     = 11'(DHT_MIN_GAP_MS);
    localparam logic [7:0]  HCSR_TO_LAST = 8'(HCSR_TIMEOUT_MS - 1);
    localparam logic [7:0]  DHT_TO_LAST  = 8'(DHT_TIMEOUT_MS - 1);

    localparam logic [1:0] ACT_NONE = 2'b00;
    localparam logic [1:0] ACT_HCSR = 2'b01;
    localparam logic [1:0] ACT_DHT  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic        r_hcsrPend;
    logic        r_dhtPend;
    logic [10:0] r_gapCnt;
    logic [7:0]  r_toCnt;
    logic        r_lastDht;     // 1 when the DHT11 owned the most recent grant
    logic [1:0]  r_active;
    logic        r_hcsrStart;
    logic        r_dhtStart;
    logic        r_hcsrTo;
    logic        r_dhtTo;
    logic        r_overrun;

    logic        w_hcsrElig;
    logic        w_dhtElig;
    logic        w_grantHcsr;
    logic        w_grantDht;
    logic        w_grant;
    logic        w_doneActive;
    logic        w_toLast;
    logic        w_toHcsr;
    logic        w_toDht;
    logic        w_release;
    logic        w_overrun;

    // The DHT11 can start only after its spacing counter has saturated
    assign w_hcsrElig = r_hcsrPend;
    assign w_dhtElig  = r_dhtPend && (r_gapCnt == GAP_FULL);
    assign w_grant    = w_grantHcsr || w_grantDht;
    assign w_release  = (r_state == ST_WAIT) && (w_stateNext == ST_IDLE);

    // A repeat request merges into the pending one. The grant cycle does not
    // count as an overrun, because the slot is being emptied at that moment.
    assign w_overrun = (iHcsrReq  && r_hcsrPend && !w_grantHcsr) ||
                       (iDht11Req && r_dhtPend  && !w_grantDht);

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Arbitration, done and timeout decisions
    always_comb begin
        w_stateNext  = r_state;
        w_grantHcsr  = 1'b0;
        w_grantDht   = 1'b0;
        w_doneActive = 1'b0;
        w_toLast     = 1'b0;
        w_toHcsr     = 1'b0;
        w_toDht      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie, the grant goes to whichever sensor was not served last
                if (w_hcsrElig && (!w_dhtElig || r_lastDht)) begin
                    w_grantHcsr = 1'b1;
                end else if (w_dhtElig) begin
                    w_grantDht = 1'b1;
                end
                if (w_grantHcsr || w_grantDht) begin
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_doneActive = ((r_active == ACT_HCSR) && iHcsrDone) ||
                               ((r_active == ACT_DHT)  && iDht11Done);
                w_toLast     = (r_active == ACT_DHT) ? (r_toCnt == DHT_TO_LAST)
                                                     : (r_toCnt == HCSR_TO_LAST);
                // A done arriving on the expiring tick still counts as success
                if (w_doneActive) begin
                    w_stateNext = ST_IDLE;
                end else if (iTick1kHz && w_toLast) begin
                    w_stateNext = ST_IDLE;
                    w_toHcsr    = (r_active == ACT_HCSR);
                    w_toDht     = (r_active == ACT_DHT);
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Pending request slots: set by a request, cleared by a grant, with the request taking priority
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_hcsrPend <= 1'b0;
            r_dhtPend  <= 1'b0;
        end else begin
            r_hcsrPend <= (r_hcsrPend && !w_grantHcsr) || iHcsrReq;
            r_dhtPend  <= (r_dhtPend  && !w_grantDht)  || iDht11Req;
        end
    end

    // DHT11 spacing counter: cleared on a DHT11 grant, counts ms ticks up to the gap limit
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_gapCnt <= GAP_FULL;
        end else if (w_grantDht) begin
            r_gapCnt <= 11'd0;
        end else if (iTick1kHz && (r_gapCnt != GAP_FULL)) begin
            r_gapCnt <= r_gapCnt + 11'd1;
        end
    end

    // Transaction watchdog: cleared on grant, counts ms ticks while waiting
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_toCnt <= 8'd0;
        end else if (w_grant) begin
            r_toCnt <= 8'd0;
        end else if ((r_state == ST_WAIT) && iTick1kHz) begin
            r_toCnt <= r_toCnt + 8'd1;
        end
    end

    // Owner of the current transaction and fairness memory
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_active  <= ACT_NONE;
            r_lastDht <= 1'b1;
        end else if (w_grantHcsr) begin
            r_active  <= ACT_HCSR;
            r_lastDht <= 1'b0;
        end else if (w_grantDht) begin
            r_active  <= ACT_DHT;
            r_lastDht <= 1'b1;
        end else if (w_release) begin
            r_active  <= ACT_NONE;
        end
    end

    // Registered one-cycle pulses to the sensor cores and status consumers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_hcsrStart <= 1'b0;
            r_dhtStart  <= 1'b0;
            r_hcsrTo    <= 1'b0;
            r_dhtTo     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_hcsrStart <= w_grantHcsr;
            r_dhtStart  <= w_grantDht;
            r_hcsrTo    <= w_toHcsr;
            r_dhtTo     <= w_toDht;
            r_overrun   <= w_overrun;
        end
    end

    assign oHcsrStart    = r_hcsrStart;
    assign oDht11Start   = r_dhtStart;
    assign oHcsrTimeout  = r_hcsrTo;
    assign oDht11Timeout = r_dhtTo;
    assign oOverrun      = r_overrun;
    assign oBusy         = (r_state == ST_WAIT);
    assign oActive       = r_active;

endmodule

// File: tb/tb_sensor_measure_scheduler.sv
// Bench for sensor_measure_scheduler. A negedge monitor logs every output
// pulse and checks it against a queue of expected (kind, cycle) events. The
// stimulus pushes an event onto that queue whenever it drives something that
// must produce a pulse. Level outputs (oBusy/oActive) are checked at chosen
// cycles. The bench starts with a table of single-cycle stimulus rows,
// followed by hand-written multi-cycle sequences.
module tb_sensor_measure_scheduler;

    logic       iClk;
    logic       iRst;
    logic       iTick1kHz;
    logic       iHcsrReq;
    logic       iDht11Req;
    logic       iHcsrDone;
    logic       iDht11Done;
    logic       oHcsrStart;
    logic       oDht11Start;
    logic       oHcsrTimeout;
    logic       oDht11Timeout;
    logic       oOverrun;
    logic       oBusy;
    logic [1:0] oActive;

    sensor_measure_scheduler dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iTick1kHz    (iTick1kHz),
        .iHcsrReq     (iHcsrReq),
        .iDht11Req    (iDht11Req),
        .iHcsrDone    (iHcsrDone),
        .iDht11Done   (iDht11Done),
        .oHcsrStart   (oHcsrStart),
        .oDht11Start  (oDht11Start),
        .oHcsrTimeout (oHcsrTimeout),
        .oDht11Timeout(oDht11Timeout),
        .oOverrun     (oOverrun),
        .oBusy        (oBusy),
        .oActive      (oActive)
    );

    // Event kinds, in the order the monitor scans them within one cycle
    localparam int K_HS  = 0;
    localparam int K_DS  = 1;
    localparam int K_HTO = 2;
    localparam int K_DTO = 3;
    localparam int K_OVR = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    typedef struct {
        int         nticks;  // ms ticks delivered (idle state) before the row
        int         gap;     // idle cycles before the row
        logic       rh;
        logic       rd;
        logic       dh;
        logic       dd;
        int         lat;     // cycles after the row at which levels are checked
        logic       xh;      // HC-SR04 start expected two cycles after the row
        logic       xd;      // DHT11 start expected two cycles after the row
        logic       xbusy;
        logic [1:0] xact;
    } vec_t;

    ev_t  q[$];
    vec_t tbl[16];
    int   cyc;
    int   n_checks;
    int   n_pass;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        q.push_back(e);
    endfunction

    // Pulse monitor
    always @(negedge iClk) begin : mon
        logic [4:0] p;
        ev_t        e;
        p = {oOverrun, oDht11Timeout, oHcsrTimeout, oDht11Start, oHcsrStart};
        if (!iRst) begin
            for (int k = 0; k < 5; k++) begin
                if (p[k]) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        $display("FAIL ev_unexpected: got kind %0d at cycle %0d, expected no pulse", k, cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.kind == k && e.cyc == cyc) begin
                            n_pass++;
                        end else begin
                            $display("FAIL ev_order: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                                     k, cyc, e.kind, e.cyc);
                        end
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs (entered and left at posedge+1)
    task automatic cyc1(input logic rh, input logic rd, input logic dh, input logic dd, input logic tk);
        iHcsrReq   = rh;
        iDht11Req  = rd;
        iHcsrDone  = dh;
        iDht11Done = dd;
        iTick1kHz  = tk;
        @(posedge iClk);
        #1;
        iHcsrReq   = 1'b0;
        iDht11Req  = 1'b0;
        iHcsrDone  = 1'b0;
        iDht11Done = 1'b0;
        iTick1kHz  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic sample(input string name, input logic busy, input logic [1:0] act);
        @(negedge iClk);
        chk({name, "_busy"}, 32'(oBusy), 32'(busy));
        chk({name, "_active"}, 32'(oActive), 32'(act));
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        chk("reset_outputs",
            32'({oHcsrStart, oDht11Start, oHcsrTimeout, oDht11Timeout, oOverrun, oBusy, oActive}), 32'd0);
        iRst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        cyc        = 0;
        n_checks   = 0;
        n_pass     = 0;
        iRst       = 1'b1;
        iTick1kHz  = 1'b0;
        iHcsrReq   = 1'b0;
        iDht11Req  = 1'b0;
        iHcsrDone  = 1'b0;
        iDht11Done = 1'b0;

        //            nticks gap  rh    rd    dh    dd    lat xh    xd    busy  act
        tbl[0]  = '{0,    3,  1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[1]  = '{0,    4,  1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b1, 2'b10};
        tbl[2]  = '{0,    4,  1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[3]  = '{1000, 2,  1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[4]  = '{0,    4,  1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b1, 2'b10};
        tbl[5]  = '{0,    4,  1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[6]  = '{0,    2,  1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[7]  = '{0,    3,  1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[8]  = '{1000, 2,  1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 2'b10};
        tbl[9]  = '{0,    3,  1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[10] = '{0,    3,  1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[11] = '{0,    9,  1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[12] = '{0,    25, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[13] = '{0,    2,  1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[14] = '{0,    3,  1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[15] = '{0,    3,  1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 2'b00};

        @(posedge iClk);
        #1;
        do_reset();

        // Table: ties, hand-over on done, fairness, ignored foreign done
        for (int i = 0; i < 16; i++) begin
            idle(tbl[i].gap);
            ticks(tbl[i].nticks);
            n = cyc;
            if (tbl[i].xh) push(K_HS, n + 2);
            if (tbl[i].xd) push(K_DS, n + 2);
            cyc1(tbl[i].rh, tbl[i].rd, tbl[i].dh, tbl[i].dd, 1'b0);
            if (tbl[i].lat == 2) idle(1);
            sample($sformatf("row%0d", i), tbl[i].xbusy, tbl[i].xact);
        end

        // DHT11 spacing: second request withheld until the 1000th tick after the grant
        do_reset();
        n = cyc;
        push(K_DS, n + 2);
        cyc1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        sample("gap_first", 1'b1, 2'b10);
        cyc1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        ticks(500);
        cyc1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        n = cyc;
        push(K_HS, n + 2);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        sample("gap_hcsr", 1'b1, 2'b01);
        cyc1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sample("gap_hold", 1'b0, 2'b00);
        ticks(499);
        t = cyc;
        push(K_DS, t + 2);
        cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        sample("gap_release", 1'b1, 2'b10);
        cyc1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // HC-SR04 timeout on the 60th tick, pending DHT11 then served and timed out
        do_reset();
        n = cyc;
        push(K_HS, n + 2);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        cyc1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(59);
        t = cyc;
        push(K_HTO, t + 1);
        push(K_DS, t + 2);
        cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sample("to_h_idle", 1'b0, 2'b00);
        sample("to_h_dht", 1'b1, 2'b10);
        ticks(29);
        t = cyc;
        push(K_DTO, t + 1);
        cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sample("to_d_idle", 1'b0, 2'b00);
        idle(3);

        // Overrun: request on grant cycle is silent, request while pending pulses once
        do_reset();
        n = cyc;
        push(K_HS, n + 2);
        push(K_OVR, n + 4);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        n = cyc;
        push(K_HS, n + 2);
        cyc1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        ticks(59);
        cyc1(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sample("done_on_to_tick", 1'b0, 2'b00);
        idle(5);
        // Done on the start-pulse cycle
        n = cyc;
        push(K_HS, n + 2);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        cyc1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sample("done_on_start", 1'b0, 2'b00);
        idle(2);

        // Asynchronous reset during a DHT11 transaction
        do_reset();
        cyc1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("pre_reset_start", 32'({oDht11Start, oBusy, oActive}), 32'b1110);
        #2;
        iRst = 1'b1;
        #1;
        chk("async_reset_outputs",
            32'({oHcsrStart, oDht11Start, oHcsrTimeout, oDht11Timeout, oOverrun, oBusy, oActive}), 32'd0);
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        ticks(40);
        n = cyc;
        push(K_DS, n + 2);
        cyc1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        sample("post_reset_dht", 1'b1, 2'b10);
        cyc1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
